// File: rtl/cgra_pkg.sv
// CGRA-wide constants and arbiter state encoding.
package cgra_pkg;

    localparam int N_COL        = 4;
    localparam int ARB_ID_WIDTH = $clog2(N_COL);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response types shared by the column arbiter and its bus neighbours.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/cgra_arb_id_fifo.sv
// In-order FIFO of granted requester IDs; push is dropped when full, pop when empty.
module cgra_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = nxt(wr_q);
        end
        if (do_pop) rd_d = nxt(rd_q);
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cgra_obi_col_arbiter.sv
// Round-robin OBI arbiter merging CGRA column masters onto one system bus port.
// Optional stall counter enabled by the CGRA_ARB_PERF_CNT_EN macro.
module cgra_obi_col_arbiter
    import obi_pkg::*;
    import cgra_pkg::*;
#(
    parameter int N_REQ           = N_COL,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  obi_req_t  [N_REQ-1:0] slv_req_i,
    output obi_resp_t [N_REQ-1:0] slv_resp_o,
    output obi_req_t              mst_req_o,
    input  obi_resp_t             mst_resp_i,
    output logic [31:0]           perf_stall_cnt_o
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic [IDW-1:0]   sel, head;
    logic             fifo_full, fifo_empty, hs, pop;
    logic [N_REQ-1:0] gnt_vec;

    // Scan from the pointer for the first active request; LOCK pins the
    // choice so address/data stay stable until the bus grants.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && slv_req_i[idx].req) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        if (state_q == LOCK) sel = lock_idx_q;
    end

    always_comb begin
        mst_req_o     = slv_req_i[sel];
        mst_req_o.req = slv_req_i[sel].req & ~fifo_full & ~rst_i;
    end

    assign hs  = mst_req_o.req & mst_resp_i.gnt;
    assign pop = mst_resp_i.rvalid & ~fifo_empty & ~rst_i;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt_vec[i]           = hs && (IDW'(i) == sel);
            slv_resp_o[i].gnt    = gnt_vec[i];
            slv_resp_o[i].rvalid = pop && (IDW'(i) == head);
            slv_resp_o[i].rdata  = mst_resp_i.rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ARB: if (mst_req_o.req && !mst_resp_i.gnt) begin
                state_d    = LOCK;
                lock_idx_d = sel;
            end
            LOCK: if (hs) state_d = ARB;
            default: state_d = ARB;
        endcase
        if (hs) ptr_d = (sel == IDW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    cgra_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

`ifdef CGRA_ARB_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        stall;

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            if (slv_req_i[i].req && !gnt_vec[i]) stall = 1'b1;
        perf_d = (stall && perf_q != 32'hFFFF_FFFF) ? perf_q + 32'd1 : perf_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cgra_obi_col_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_cgra_obi_col_arbiter;
    import obi_pkg::*;
    import cgra_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 2;

    logic              clk = 1'b0;
    logic              rst;
    obi_req_t  [N-1:0] slv_req;
    obi_resp_t [N-1:0] slv_resp;
    obi_req_t          mst_req;
    obi_resp_t         mst_resp;
    logic [31:0]       perf;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_ptr;
    bit          m_lock;
    int          m_lidx;
    int          m_q[$];
    int          m_perf;
    logic [31:0] col_addr [N];

    always #5 clk = ~clk;

    cgra_obi_col_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .perf_stall_cnt_o (perf)
    );

    function automatic logic [N-1:0] obs_gnt();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = slv_resp[i].gnt;
        return v;
    endfunction

    function automatic logic [N-1:0] obs_rv();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = slv_resp[i].rvalid;
        return v;
    endfunction

    task automatic drive(input logic [N-1:0] rq, input logic g, input logic rv, input logic [31:0] rd);
        for (int i = 0; i < N; i++) begin
            slv_req[i].req   = rq[i];
            slv_req[i].addr  = col_addr[i];
            slv_req[i].we    = 1'((i & 1) != 0);
            slv_req[i].be    = 4'hF;
            slv_req[i].wdata = ~col_addr[i];
        end
        mst_resp.gnt    = g;
        mst_resp.rvalid = rv;
        mst_resp.rdata  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst    = 1'b0;
        m_ptr  = 0;
        m_lock = 0;
        m_lidx = 0;
        m_q.delete();
        m_perf = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++; if (mst_req.req !== 1'b0) begin n_fail++; $display("FAIL rst_mst_req got=%b exp=0", mst_req.req); end
        n_checks++; if (obs_gnt() !== '0) begin n_fail++; $display("FAIL rst_gnt got=%b exp=0", obs_gnt()); end
        n_checks++; if (obs_rv() !== '0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0", obs_rv()); end
        n_checks++; if (perf !== 32'h0) begin n_fail++; $display("FAIL rst_perf got=%0d exp=0", perf); end
        tick();
        rst = 1'b0;
        drive('0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(4'hF, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs_gnt() !== N'(1 << (k % N))) begin
                n_fail++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, obs_gnt(), N'(1 << (k % N)));
            end
            n_checks++;
            if (mst_req.addr !== col_addr[k % N]) begin
                n_fail++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, mst_req.addr, col_addr[k % N]);
            end
            tick();
        end
    endtask

    task automatic test_lock();
        do_reset();
        drive(4'b0100, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (mst_req.req !== 1'b1 || mst_req.addr !== col_addr[2]) begin
                n_fail++; $display("FAIL lock_wait k=%0d got req=%b addr=%h exp req=1 addr=%h", k, mst_req.req, mst_req.addr, col_addr[2]);
            end
            tick();
        end
        drive(4'b0101, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (mst_req.addr !== col_addr[2]) begin n_fail++; $display("FAIL lock_hold got=%h exp=%h", mst_req.addr, col_addr[2]); end
        tick();
        drive(4'b0101, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (obs_gnt() !== 4'b0100) begin n_fail++; $display("FAIL lock_gnt got=%b exp=0100", obs_gnt()); end
        tick();
        @(negedge clk);
        n_checks++; if (mst_req.addr !== col_addr[0] || obs_gnt() !== 4'b0001) begin
            n_fail++; $display("FAIL lock_next got addr=%h gnt=%b exp addr=%h gnt=0001", mst_req.addr, obs_gnt(), col_addr[0]);
        end
        tick();
    endtask

    task automatic test_outstanding();
        do_reset();
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (obs_gnt() !== 4'b0001) begin n_fail++; $display("FAIL out_g0 got=%b exp=0001", obs_gnt()); end
        tick();
        @(negedge clk);
        n_checks++; if (obs_gnt() !== 4'b0010) begin n_fail++; $display("FAIL out_g1 got=%b exp=0010", obs_gnt()); end
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (mst_req.req !== 1'b0) begin n_fail++; $display("FAIL out_block k=%0d got=%b exp=0", k, mst_req.req); end
            tick();
        end
        drive(4'b0011, 1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk);
        n_checks++; if (mst_req.req !== 1'b0) begin n_fail++; $display("FAIL out_block_rv got=%b exp=0", mst_req.req); end
        n_checks++; if (obs_rv() !== 4'b0001) begin n_fail++; $display("FAIL out_rv got=%b exp=0001", obs_rv()); end
        tick();
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (mst_req.req !== 1'b1 || obs_gnt() !== 4'b0001) begin
            n_fail++; $display("FAIL out_resume got req=%b gnt=%b exp req=1 gnt=0001", mst_req.req, obs_gnt());
        end
        tick();
    endtask

    task automatic test_resp_order();
        do_reset();
        drive(4'b0010, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (obs_gnt() !== 4'b0010) begin n_fail++; $display("FAIL ord_g1 got=%b exp=0010", obs_gnt()); end
        tick();
        drive(4'b1000, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (obs_gnt() !== 4'b1000) begin n_fail++; $display("FAIL ord_g3 got=%b exp=1000", obs_gnt()); end
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'hA5A5_A5A5);
        @(negedge clk);
        n_checks++; if (obs_rv() !== 4'b0010 || slv_resp[1].rdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL ord_r1 got rv=%b data=%h exp rv=0010 data=a5a5a5a5", obs_rv(), slv_resp[1].rdata);
        end
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h5A5A_5A5A);
        @(negedge clk);
        n_checks++; if (obs_rv() !== 4'b1000 || slv_resp[3].rdata !== 32'h5A5A_5A5A) begin
            n_fail++; $display("FAIL ord_r3 got rv=%b data=%h exp rv=1000 data=5a5a5a5a", obs_rv(), slv_resp[3].rdata);
        end
        tick();
        drive('0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        drive('0, 1'b0, 1'b1, 32'h0BAD_0BAD);
        @(negedge clk);
        n_checks++; if (obs_rv() !== '0) begin n_fail++; $display("FAIL mid_stray_rv got=%b exp=0", obs_rv()); end
        tick();
        drive(4'b0001, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++; if (mst_req.req !== 1'b1) begin n_fail++; $display("FAIL mid_cnt k=%0d got=%b exp=1", k, mst_req.req); end
            tick();
        end
        drive('0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_perf();
        logic [31:0] exp_p;
        do_reset();
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        repeat (5) tick();
        drive('0, 1'b0, 1'b0, 32'h0);
`ifdef CGRA_ARB_PERF_CNT_EN
        exp_p = 32'd5;
`else
        exp_p = 32'd0;
`endif
        @(negedge clk);
        n_checks++; if (perf !== exp_p) begin n_fail++; $display("FAIL perf_wait5 got=%0d exp=%0d", perf, exp_p); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] rq, exp_gnt, exp_rv;
        logic         g, rv, exp_req;
        logic [31:0]  rd, exp_p;
        int           sel;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) col_addr[i] = $urandom;
            rq = N'($urandom);
            g  = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 2) == 0);
            rd = $urandom;
            drive(rq, g, rv, rd);
            if (m_lock) sel = m_lidx;
            else begin
                sel = m_ptr;
                for (int k = N - 1; k >= 0; k--)
                    if (rq[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            end
            exp_req = rq[sel] && (m_q.size() < MAXO);
            exp_gnt = (exp_req && g) ? N'(1 << sel) : '0;
            exp_rv  = (rv && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
            @(negedge clk);
            n_checks++; if (mst_req.req !== exp_req) begin n_fail++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, mst_req.req, exp_req); end
            n_checks++; if (mst_req.addr !== col_addr[sel]) begin n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mst_req.addr, col_addr[sel]); end
            n_checks++; if (obs_gnt() !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, obs_gnt(), exp_gnt); end
            n_checks++; if (obs_rv() !== exp_rv) begin n_fail++; $display("FAIL rnd_rv c=%0d got=%b exp=%b", c, obs_rv(), exp_rv); end
            n_checks++; if (slv_resp[c % N].rdata !== rd) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, slv_resp[c % N].rdata, rd); end
            if ((rq & ~exp_gnt) != '0) m_perf++;
            if (rv && m_q.size() > 0) void'(m_q.pop_front());
            if (exp_req && g) begin
                m_q.push_back(sel);
                m_ptr  = (sel + 1) % N;
                m_lock = 0;
            end else if (exp_req && !m_lock) begin
                m_lock = 1;
                m_lidx = sel;
            end
            tick();
        end
        drive('0, 1'b0, 1'b0, 32'h0);
`ifdef CGRA_ARB_PERF_CNT_EN
        exp_p = 32'(m_perf);
`else
        exp_p = 32'd0;
`endif
        @(negedge clk);
        n_checks++; if (perf !== exp_p) begin n_fail++; $display("FAIL rnd_perf got=%0d exp=%0d", perf, exp_p); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) col_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 32'h0);
        #2;
        test_reset();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_resp_order();
        test_reset_mid();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
